mmu_mem_responder: RTL
======================

// Module: mmu_mem_responder
// PURPOSE
//  Memory-side responder for the MMU request/response interface; it plays the
//  D-cache/bus role for page-table walks and translated accesses.
//  Serves one outstanding request at a time from an internal 64-bit-word RAM.
//  Response latency is configurable, and faults are generated for range or
//  alignment violations.
//  Used as a tightly-coupled page-table store and as the unit-level partner of
//  the MMU FSM.
// PARAMETERS
//  abits    10  RAM depth = 2**abits 64-bit words (byte span 2**(abits+3))
//  latency  2   cycles from request accept to o_resp_valid; legal range 1..15
// PORTS
//  i_clk          in   1                clock
//  i_nrst         in   1                reset, synchronous, active-low
//  i_req_valid    in   1                request strobe
//  o_req_ready    out  1                request accepted when valid&ready
//  i_req_type     in   MemopType_Total  bit MemopType_Store=1 means write
//  i_req_addr     in   RISCV_ARCH       byte address
//  i_req_wdata    in   64               write data, dword-lane aligned
//  i_req_wstrb    in   8                byte enables for write
//  i_req_size     in   2                0=1B 1=2B 2=4B 3=8B
//  i_req_flush    in   1                flush request; acknowledged, no data
//  o_resp_valid   out  1                response strobe
//  i_resp_ready   in   1                response consumed when valid&ready
//  o_resp_addr    out  RISCV_ARCH       copy of accepted i_req_addr
//  o_resp_data    out  64               full aligned dword (reads), 0 otherwise
//  o_resp_load_fault  out 1             read violated range/alignment
//  o_resp_store_fault out 1             write violated range/alignment
// BEHAVIOUR
//  - Reset (i_nrst=0 at posedge): state=Idle, latency counter=0, all o_resp_*=0,
//    o_req_ready=1 on the next cycle.
//  - RAM contents are not reset.
//  - Reset mid-transaction drops the request silently; no response is issued.
//  - FSM states:
//    Idle -> Wait on accept (if latency>1); Idle -> Resp directly if latency==1.
//    Wait: counter decrements; at 1 -> Resp.
//    Resp: o_resp_valid=1; on i_resp_ready -> Idle.
//  - o_req_ready=1 only in Idle (combinational on state), so back-to-back
//    throughput is one request per latency+1 cycles minimum.
//  - On accept, latch type, addr, wdata, wstrb, size and flush.
//  - Fault check at accept:
//    - out of range: |addr[RISCV_ARCH-1:abits+3]
//    - misaligned: addr[2:0] & ((1<<size)-1) != 0
//  - Write without fault: apply wstrb bytewise to RAM[addr[abits+2:3]] at accept
//    time; the response comes later.
//  - Faulting write: RAM is unchanged; store_fault=1.
//  - Read without fault: RAM read at accept; data held in a register until the
//    response is consumed.
//  - Faulting read: data=0; load_fault=1.
//  - Flush (i_req_flush=1): no RAM access, no fault check.
//    Response has data=0 and both faults=0. Type is ignored.
//  - Read-after-write to the same word returns the new data (the write commits
//    before any later accept).
//  - o_resp_* are stable while o_resp_valid=1 and i_resp_ready=0.
//  - o_resp_* return to 0 the cycle after the handshake.
//  - Latency counter width is 4 bits; wrap-around cannot occur.
// CONFIGURATION
//  RIVER_MMU_RESP_FAULT_INJ_EN:
//    - Defined: adds input i_inject_fault (1 bit). A pulse arms a sticky flag.
//    - The next non-flush accept gets load_fault/store_fault forced by its type,
//      suppresses the RAM write, and clears the flag.
//    - A pulse coincident with an accept applies to that accept.
//  Undefined: the port is absent and there is no injection logic.
// STRUCTURE
//  - Shared package mmu_resp_pkg holds:
//    - state constants Idle=0, Wait=1, Resp=2
//    - typedef MmuResp_registers (state, cnt, req_addr, resp_data, faults,
//      flush, inj flag)
//    - const MmuResp_r_reset
//  - RAM is one sub-module ram_mmu_resp_tech (abits, 64-bit, 8 byte-enables,
//    1-cycle read).
//  - Everything else is in comb/seq blocks.
// TESTING
//  1. Write addr=0x100 wdata=0x0123456789ABCDEF wstrb=0xFF size=3, then read
//     0x100 -> resp_data=0x0123456789ABCDEF, faults=0, resp_addr=0x100.
//  2. latency=3: read accepted at cycle T -> o_resp_valid first high at T+3;
//     o_req_ready low T+1..until the handshake.
//  3. Read addr=0x104 size=3 -> load_fault=1, data=0.
//     Write addr=(1<<(abits+3)) -> store_fault=1; re-reading word 0 is unchanged.
//  4. Hold i_resp_ready=0 for 5 cycles in Resp -> outputs stable; a new
//     i_req_valid is not accepted.
//  5. Partial write wstrb=0x0F data=0xFFFFFFFF over 0x0123456789ABCDEF
//     -> read 0x01234567FFFFFFFF.
//  6. Assert i_nrst=0 during Wait -> no response; the next request completes
//     normally. With FAULT_INJ_EN: pulse inject then read -> load_fault=1 once.

Source files
------------

// File: rtl/mmu_resp_pkg.sv
// Shared types and constants for the MMU memory-side responder.
// Optional feature macro used by the top: RIVER_MMU_RESP_FAULT_INJ_EN.
package mmu_resp_pkg;

    localparam int RISCV_ARCH      = 64;
    localparam int MemopType_Store = 0;
    localparam int MemopType_Total = 4;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Wait = 2'd1,
        Resp = 2'd2
    } mmu_resp_state_t;

    typedef struct packed {
        mmu_resp_state_t        state;
        logic [3:0]             cnt;
        logic [RISCV_ARCH-1:0]  req_addr;
        logic [63:0]            resp_data;
        logic                   load_fault;
        logic                   store_fault;
        logic                   flush;
        logic                   inj;
        logic                   rd_pend;
    } MmuResp_registers;

    localparam MmuResp_registers MmuResp_r_reset = '{
        state:       Idle,
        cnt:         4'd0,
        req_addr:    '0,
        resp_data:   64'd0,
        load_fault:  1'b0,
        store_fault: 1'b0,
        flush:       1'b0,
        inj:         1'b0,
        rd_pend:     1'b0
    };

    // Access is misaligned when any address bit below the access size is set.
    function automatic logic misaligned(input logic [2:0] addr, input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return |(addr & mask);
    endfunction

endpackage

// File: rtl/mmu_mem_responder_if.sv
// Request/response bus between the MMU (master) and its memory responder (slave).
interface mmu_mem_responder_if;
    import mmu_resp_pkg::*;

    logic                        req_valid;
    logic                        req_ready;
    logic [MemopType_Total-1:0]  req_type;
    logic [RISCV_ARCH-1:0]       req_addr;
    logic [63:0]                 req_wdata;
    logic [7:0]                  req_wstrb;
    logic [1:0]                  req_size;
    logic                        req_flush;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [RISCV_ARCH-1:0]       resp_addr;
    logic [63:0]                 resp_data;
    logic                        resp_load_fault;
    logic                        resp_store_fault;

    modport master (
        output req_valid, req_type, req_addr, req_wdata, req_wstrb, req_size, req_flush,
        output resp_ready,
        input  req_ready, resp_valid, resp_addr, resp_data, resp_load_fault, resp_store_fault
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, req_wstrb, req_size, req_flush,
        input  resp_ready,
        output req_ready, resp_valid, resp_addr, resp_data, resp_load_fault, resp_store_fault
    );

endinterface

// File: rtl/ram_mmu_resp_tech.sv
// Single-port 64-bit RAM with byte enables and a registered (1-cycle) read port.
module ram_mmu_resp_tech #(
    parameter int abits = 10
) (
    input  logic              i_clk,
    input  logic [abits-1:0]  i_addr,
    input  logic              i_wena,
    input  logic [7:0]        i_wstrb,
    input  logic [63:0]       i_wdata,
    input  logic              i_rena,
    output logic [63:0]       o_rdata
);

    logic [63:0] mem [0:(1<<abits)-1];

    // Byte-lane writes and registered read; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_wena) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wstrb[b]) begin
                    mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_rena) begin
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/mmu_mem_responder.sv
// Memory-side responder for the MMU: one outstanding request, fixed response
// latency, range/alignment fault generation, internal 64-bit word RAM.
// Optional: RIVER_MMU_RESP_FAULT_INJ_EN adds i_inject_fault, which arms a
// sticky flag that forces a fault on the next non-flush accept.
module mmu_mem_responder
    import mmu_resp_pkg::*;
#(
    parameter int abits   = 10,
    parameter int latency = 2
) (
    input  logic i_clk,
    input  logic i_nrst,
`ifdef RIVER_MMU_RESP_FAULT_INJ_EN
    input  logic i_inject_fault,
`endif
    mmu_mem_responder_if.slave bus
);

    localparam logic [3:0] LatCnt = 4'(latency - 1);

    MmuResp_registers r;
    MmuResp_registers v;

    logic        req_ready;
    logic        accept;
    logic        is_store;
    logic        range_err;
    logic        align_err;
    logic        inj_now;
    logic        fault;
    logic        ram_wena;
    logic        ram_rena;
    logic [63:0] ram_rdata;
    logic        unused_type;

    assign req_ready = (r.state == Idle);
    assign accept    = bus.req_valid & req_ready;
    assign is_store  = bus.req_type[MemopType_Store];
    assign range_err = |bus.req_addr[RISCV_ARCH-1:abits+3];
    assign align_err = misaligned(bus.req_addr[2:0], bus.req_size);
    assign unused_type = ^bus.req_type;

`ifdef RIVER_MMU_RESP_FAULT_INJ_EN
    assign inj_now = r.inj | i_inject_fault;
`else
    assign inj_now = 1'b0;
`endif

    assign fault = range_err | align_err | inj_now;

    ram_mmu_resp_tech #(
        .abits(abits)
    ) u_ram (
        .i_clk   (i_clk),
        .i_addr  (bus.req_addr[abits+2:3]),
        .i_wena  (ram_wena),
        .i_wstrb (bus.req_wstrb),
        .i_wdata (bus.req_wdata),
        .i_rena  (ram_rena),
        .o_rdata (ram_rdata)
    );

    // Next-state logic: accept/fault decision, latency countdown, response handshake.
    always_comb begin
        v        = r;
        ram_wena = 1'b0;
        ram_rena = 1'b0;
        v.inj    = inj_now;

        // RAM data lands one cycle after the accept; hold it until consumed.
        if (r.rd_pend) begin
            v.resp_data = ram_rdata;
            v.rd_pend   = 1'b0;
        end

        case (r.state)
            Idle: begin
                if (accept) begin
                    v.req_addr    = bus.req_addr;
                    v.flush       = bus.req_flush;
                    v.resp_data   = 64'd0;
                    v.load_fault  = 1'b0;
                    v.store_fault = 1'b0;
                    v.rd_pend     = 1'b0;
                    if (!bus.req_flush) begin
                        v.inj = 1'b0;
                        if (fault) begin
                            v.store_fault = is_store;
                            v.load_fault  = ~is_store;
                        end else if (is_store) begin
                            ram_wena = 1'b1;
                        end else begin
                            ram_rena  = 1'b1;
                            v.rd_pend = 1'b1;
                        end
                    end
                    if (latency == 1) begin
                        v.state = Resp;
                    end else begin
                        v.state = Wait;
                        v.cnt   = LatCnt;
                    end
                end
            end
            Wait: begin
                if (r.cnt <= 4'd1) begin
                    v.state = Resp;
                    v.cnt   = 4'd0;
                end else begin
                    v.cnt = r.cnt - 4'd1;
                end
            end
            Resp: begin
                if (bus.resp_ready) begin
                    v.state       = Idle;
                    v.req_addr    = '0;
                    v.resp_data   = 64'd0;
                    v.load_fault  = 1'b0;
                    v.store_fault = 1'b0;
                    v.flush       = 1'b0;
                    v.rd_pend     = 1'b0;
                end
            end
            default: begin
                v.state = Idle;
            end
        endcase
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r <= MmuResp_r_reset;
        end else begin
            r <= v;
        end
    end

    assign bus.req_ready        = req_ready;
    assign bus.resp_valid       = (r.state == Resp);
    assign bus.resp_addr        = (r.state == Resp) ? r.req_addr : '0;
    assign bus.resp_data        = (r.state != Resp) ? 64'd0 :
                                  (r.rd_pend ? ram_rdata : r.resp_data);
    assign bus.resp_load_fault  = (r.state == Resp) & r.load_fault;
    assign bus.resp_store_fault = (r.state == Resp) & r.store_fault;

endmodule
